// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation and FSM state encodings.
package mdu_pkg;

    // i_Op encodings; bit 1 selects divide, bit 0 selects unsigned
    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_SIGN = 2'b10
    } mdu_state_e;

endpackage : mdu_pkg

// File: rtl/mdu_iter_core.sv
// Shared iterative datapath: W-step shift-add multiply or restoring divide on magnitudes.
// Optional MDU_FAST_MUL_EN: multiply result comes from a combinational W x W multiplier.
// Ports:
//   clk_i, rst_ni   clock / async active-low reset
//   load_i          load magnitudes a_i, b_i and clear accumulator/counter
//   step_i          perform one iteration step
//   is_div_i        selects divide step (1) or multiply step (0)
//   a_i, b_i        multiplicand/dividend and multiplier/divisor magnitudes
//   last_c_o        current step is the final (W-th) one
//   res_c_o         {HI,LO} raw result: product, or {remainder, quotient}
module mdu_iter_core #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 6
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    load_i,
    input  logic                    step_i,
    input  logic                    is_div_i,
    input  logic [DATA_WIDTH-1:0]   a_i,
    input  logic [DATA_WIDTH-1:0]   b_i,
    output logic                    last_c_o,
    output logic [2*DATA_WIDTH-1:0] res_c_o
);

    localparam int unsigned W = DATA_WIDTH;

    logic [W-1:0]         acc_q, acc_d;
    logic [W-1:0]         quo_q, quo_d;
    logic [W-1:0]         b_q, b_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic [W-1:0] addend;
    logic [W:0]   add_sum;
    logic [W:0]   shl;
    logic         sub_ok;
    logic [W-1:0] sub_diff;

    // Datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
            quo_q <= '0;
            b_q   <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            quo_q <= quo_d;
            b_q   <= b_d;
            cnt_q <= cnt_d;
        end
    end

    // One iteration step; quo_q holds the multiplier (mult) or shifts dividend out / quotient in (div)
    always_comb begin
        acc_d = acc_q;
        quo_d = quo_q;
        b_d   = b_q;
        cnt_d = cnt_q;

        addend  = quo_q[0] ? b_q : '0;
        add_sum = {1'b0, acc_q} + {1'b0, addend};
        shl     = {acc_q, quo_q[W-1]};
        sub_ok  = (shl >= {1'b0, b_q});
        // When sub_ok the true difference is below b_q, so W bits suffice
        sub_diff = shl[W-1:0] - b_q;

        if (load_i) begin
            acc_d = '0;
            quo_d = a_i;
            b_d   = b_i;
            cnt_d = '0;
        end else if (step_i) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
            if (is_div_i) begin
                if (sub_ok) begin
                    acc_d = sub_diff;
                    quo_d = {quo_q[W-2:0], 1'b1};
                end else begin
                    acc_d = shl[W-1:0];
                    quo_d = {quo_q[W-2:0], 1'b0};
                end
            end else begin
                acc_d = add_sum[W:1];
                quo_d = {add_sum[0], quo_q[W-1:1]};
            end
        end
    end

    assign last_c_o = (cnt_q == CNT_WIDTH'(W - 1));

`ifdef MDU_FAST_MUL_EN
    // Multiplies never step in this build, so quo_q/b_q still hold the loaded magnitudes
    logic [2*W-1:0] fast_prod;
    assign fast_prod = (2*W)'(quo_q) * (2*W)'(b_q);
    assign res_c_o   = is_div_i ? {acc_q, quo_q} : fast_prod;
`else
    assign res_c_o = {acc_q, quo_q};
`endif

endmodule : mdu_iter_core

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Optional build macro MDU_FAST_MUL_EN: single-cycle MULT/MULTU; divide unchanged.
// Ports:
//   i_CLK, i_RST     clock / async active-low reset
//   i_Start, i_Op    start an operation (IDLE only); 00 MULT 01 MULTU 10 DIV 11 DIVU
//   i_SrcA, i_SrcB   multiplicand/dividend, multiplier/divisor
//   i_WrHi, i_WrLo   MTHI/MTLO strobes with data i_WrData (IDLE only)
//   i_Flush          abort any operation, no result written
//   o_Busy           operation in flight
//   o_Done           one-cycle pulse, HI/LO updated
//   o_DivByZero      pulses with o_Done for a divide by zero
//   o_Hi, o_Lo       HI/LO registers
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 6
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic                  i_Start,
    input  logic [1:0]            i_Op,
    input  logic [DATA_WIDTH-1:0] i_SrcA,
    input  logic [DATA_WIDTH-1:0] i_SrcB,
    input  logic                  i_WrHi,
    input  logic                  i_WrLo,
    input  logic [DATA_WIDTH-1:0] i_WrData,
    input  logic                  i_Flush,
    output logic                  o_Busy,
    output logic                  o_Done,
    output logic                  o_DivByZero,
    output logic [DATA_WIDTH-1:0] o_Hi,
    output logic [DATA_WIDTH-1:0] o_Lo
);

    localparam int unsigned W = DATA_WIDTH;

    mdu_state_e state_q, state_d;
    logic [W-1:0] hi_q, hi_d, lo_q, lo_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic dbz_out_q, dbz_out_d;
    logic div_zero_q, div_zero_d;
    logic is_div_q, is_div_d;
    logic res_neg_q, res_neg_d;
    logic rem_neg_q, rem_neg_d;

    logic           load_c, step_c, last_c;
    logic           op_signed, op_div;
    logic [W-1:0]   a_mag, b_mag;
    logic [2*W-1:0] core_res, mul_fixed;
    logic [W-1:0]   quo_fixed, rem_fixed;

    mdu_iter_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_core (
        .clk_i    (i_CLK),
        .rst_ni   (i_RST),
        .load_i   (load_c),
        .step_i   (step_c),
        .is_div_i (is_div_q),
        .a_i      (a_mag),
        .b_i      (b_mag),
        .last_c_o (last_c),
        .res_c_o  (core_res)
    );

    // Operand decode and magnitudes for the start edge
    always_comb begin
        op_signed = (i_Op == MDU_MULT) || (i_Op == MDU_DIV);
        op_div    = (i_Op == MDU_DIV)  || (i_Op == MDU_DIVU);
        a_mag     = (op_signed && i_SrcA[W-1]) ? (W'(0) - i_SrcA) : i_SrcA;
        b_mag     = (op_signed && i_SrcB[W-1]) ? (W'(0) - i_SrcB) : i_SrcB;
    end

    // Sign correction of the raw core result
    always_comb begin
        mul_fixed = res_neg_q ? ((2*W)'(0) - core_res) : core_res;
        quo_fixed = res_neg_q ? (W'(0) - core_res[W-1:0]) : core_res[W-1:0];
        rem_fixed = rem_neg_q ? (W'(0) - core_res[2*W-1:W]) : core_res[2*W-1:W];
    end

    // State and output registers
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            state_q    <= ST_IDLE;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_out_q  <= 1'b0;
            div_zero_q <= 1'b0;
            is_div_q   <= 1'b0;
            res_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dbz_out_q  <= dbz_out_d;
            div_zero_q <= div_zero_d;
            is_div_q   <= is_div_d;
            res_neg_q  <= res_neg_d;
            rem_neg_q  <= rem_neg_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        dbz_out_d  = 1'b0;
        div_zero_d = div_zero_q;
        is_div_d   = is_div_q;
        res_neg_d  = res_neg_q;
        rem_neg_d  = rem_neg_q;
        load_c     = 1'b0;
        step_c     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_WrHi) hi_d = i_WrData;
                if (i_WrLo) lo_d = i_WrData;
                if (i_Start && !i_Flush) begin
                    load_c     = 1'b1;
                    is_div_d   = op_div;
                    res_neg_d  = op_signed && (i_SrcA[W-1] ^ i_SrcB[W-1]);
                    rem_neg_d  = op_signed && op_div && i_SrcA[W-1];
                    div_zero_d = op_div && (i_SrcB == '0);
`ifdef MDU_FAST_MUL_EN
                    state_d = (div_zero_d || !op_div) ? ST_SIGN : ST_RUN;
`else
                    state_d = div_zero_d ? ST_SIGN : ST_RUN;
`endif
                end
            end
            ST_RUN: begin
                step_c = 1'b1;
                if (last_c) state_d = ST_SIGN;
            end
            ST_SIGN: begin
                state_d   = ST_IDLE;
                done_d    = 1'b1;
                dbz_out_d = div_zero_q;
                if (!div_zero_q) begin
                    if (is_div_q) begin
                        hi_d = rem_fixed;
                        lo_d = quo_fixed;
                    end else begin
                        hi_d = mul_fixed[2*W-1:W];
                        lo_d = mul_fixed[W-1:0];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Flush squashes whatever is in flight, including a same-edge start or final write
        if (i_Flush) begin
            state_d   = ST_IDLE;
            load_c    = 1'b0;
            step_c    = 1'b0;
            done_d    = 1'b0;
            dbz_out_d = 1'b0;
            if (state_q != ST_IDLE) begin
                hi_d = hi_q;
                lo_d = lo_q;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    assign o_Busy      = busy_q;
    assign o_Done      = done_q;
    assign o_DivByZero = dbz_out_q;
    assign o_Hi        = hi_q;
    assign o_Lo        = lo_q;

endmodule : mult_div_unit

// File: tb/tb_mult_div_unit.sv
// Table-driven, scoreboard-checked bench for mult_div_unit (W=32).
module tb_mult_div_unit;

    localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
    localparam int MUL_BUSY = 1;
`else
    localparam int MUL_BUSY = 33;
`endif
    localparam int DIV_BUSY = 33;

    logic          i_CLK = 1'b0;
    logic          i_RST;
    logic          i_Start = 1'b0;
    logic [1:0]    i_Op = 2'b00;
    logic [W-1:0]  i_SrcA = '0;
    logic [W-1:0]  i_SrcB = '0;
    logic          i_WrHi = 1'b0;
    logic          i_WrLo = 1'b0;
    logic [W-1:0]  i_WrData = '0;
    logic          i_Flush = 1'b0;
    logic          o_Busy, o_Done, o_DivByZero;
    logic [W-1:0]  o_Hi, o_Lo;

    mult_div_unit #(.DATA_WIDTH(W), .CNT_WIDTH(6)) dut (
        .i_CLK       (i_CLK),
        .i_RST       (i_RST),
        .i_Start     (i_Start),
        .i_Op        (i_Op),
        .i_SrcA      (i_SrcA),
        .i_SrcB      (i_SrcB),
        .i_WrHi      (i_WrHi),
        .i_WrLo      (i_WrLo),
        .i_WrData    (i_WrData),
        .i_Flush     (i_Flush),
        .o_Busy      (o_Busy),
        .o_Done      (o_Done),
        .o_DivByZero (o_DivByZero),
        .o_Hi        (o_Hi),
        .o_Lo        (o_Lo)
    );

    always #5 i_CLK = ~i_CLK;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } exp_t;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           busy;
    } vec_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   done_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every o_Done pulse must match the oldest expected result
    always @(negedge i_CLK) begin
        exp_t e;
        if (i_RST && o_Done) begin
            done_seen++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got o_Done=1 expected no pulse");
            end else begin
                e = sb_q.pop_front();
                check("done_hi", 64'(o_Hi), 64'(e.hi));
                check("done_lo", 64'(o_Lo), 64'(e.lo));
                check("done_dbz", 64'(o_DivByZero), 64'(e.dbz));
            end
        end
    end

    task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge i_CLK);
        i_Start = 1'b1; i_Op = op; i_SrcA = a; i_SrcB = b;
        @(negedge i_CLK);
        i_Start = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] hi, input logic [W-1:0] lo,
                          input logic dbz, input int busy_exp);
        exp_t e;
        int   cnt;
        e.hi = hi; e.lo = lo; e.dbz = dbz;
        sb_q.push_back(e);
        start_op(op, a, b);
        cnt = 0;
        while (o_Busy && cnt < 200) begin
            cnt++;
            @(negedge i_CLK);
        end
        check({name, "_busy_cycles"}, 64'(cnt), 64'(busy_exp));
        check({name, "_done_at_end"}, 64'(o_Done), 64'(1));
        @(negedge i_CLK);
        check({name, "_done_single"}, 64'(o_Done), 64'(0));
    endtask

    task automatic write_hilo(input logic [W-1:0] hi, input logic [W-1:0] lo);
        @(negedge i_CLK);
        i_WrHi = 1'b1; i_WrData = hi;
        @(negedge i_CLK);
        i_WrHi = 1'b0; i_WrLo = 1'b1; i_WrData = lo;
        @(negedge i_CLK);
        i_WrLo = 1'b0;
        check("mthi", 64'(o_Hi), 64'(hi));
        check("mtlo", 64'(o_Lo), 64'(lo));
    endtask

    vec_t vecs[10];

    initial begin
        int busy_cnt;
        int done_before;

        vecs[0] = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, MUL_BUSY};
        vecs[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_BUSY};
        vecs[2] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_BUSY};
        vecs[3] = '{2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, DIV_BUSY};
        vecs[4] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_BUSY};
        vecs[5] = '{2'b00, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, MUL_BUSY};
        vecs[6] = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DIV_BUSY};
        vecs[7] = '{2'b11, 32'h80000000, 32'h00000003, 32'h00000002, 32'h2AAAAAAA, DIV_BUSY};
        vecs[8] = '{2'b10, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, DIV_BUSY};
        vecs[9] = '{2'b01, 32'h00000000, 32'h00012345, 32'h00000000, 32'h00000000, MUL_BUSY};

        // Reset state
        i_RST = 1'b1;
        #2 i_RST = 1'b0;
        repeat (2) @(negedge i_CLK);
        check("rst_hi", 64'(o_Hi), 64'(0));
        check("rst_lo", 64'(o_Lo), 64'(0));
        check("rst_busy", 64'(o_Busy), 64'(0));
        check("rst_done", 64'(o_Done), 64'(0));
        check("rst_dbz", 64'(o_DivByZero), 64'(0));
        i_RST = 1'b1;

        write_hilo(32'h12345678, 32'h9ABCDEF0);

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, 1'b0, vecs[i].busy);

        // Divide by zero keeps HI/LO and finishes one edge after start
        write_hilo(32'h000000AA, 32'h00000055);
        run_op("div0", 2'b10, 32'd5, 32'd0, 32'h000000AA, 32'h00000055, 1'b1, 1);

        // Flush mid-divide, with an ignored start while busy
        done_before = done_seen;
        start_op(2'b11, 32'd100, 32'd7);
        repeat (4) @(negedge i_CLK);
        i_Start = 1'b1; i_Op = 2'b01; i_SrcA = 32'd9; i_SrcB = 32'd9;
        @(negedge i_CLK);
        i_Start = 1'b0;
        check("flush_busy_mid", 64'(o_Busy), 64'(1));
        repeat (4) @(negedge i_CLK);
        check("flush_busy_pre", 64'(o_Busy), 64'(1));
        i_Flush = 1'b1;
        @(negedge i_CLK);
        i_Flush = 1'b0;
        check("flush_busy_post", 64'(o_Busy), 64'(0));
        busy_cnt = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge i_CLK);
            if (o_Busy) busy_cnt++;
        end
        check("flush_stays_idle", 64'(busy_cnt), 64'(0));
        check("flush_no_done", 64'(done_seen - done_before), 64'(0));
        check("flush_hi_kept", 64'(o_Hi), 64'(32'h000000AA));
        check("flush_lo_kept", 64'(o_Lo), 64'(32'h00000055));

        // Asynchronous reset in the middle of an operation
        start_op(2'b11, 32'd1000, 32'd3);
        repeat (11) @(negedge i_CLK);
        check("arst_busy_pre", 64'(o_Busy), 64'(1));
        @(posedge i_CLK);
        #3 i_RST = 1'b0;
        #1;
        check("arst_hi", 64'(o_Hi), 64'(0));
        check("arst_lo", 64'(o_Lo), 64'(0));
        check("arst_busy", 64'(o_Busy), 64'(0));
        check("arst_done", 64'(o_Done), 64'(0));
        check("arst_dbz", 64'(o_DivByZero), 64'(0));
        @(negedge i_CLK);
        i_RST = 1'b1;
        run_op("post_rst_mul", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, MUL_BUSY);

        repeat (3) @(negedge i_CLK);
        check("sb_empty", 64'(sb_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mult_div_unit
